// File: rtl/scan_chain_loader_pkg.sv
// Shared definitions for the scan chain loader: FSM encoding, byte width and the
// CRC-8 polynomial with its single-bit update step.
package scan_chain_loader_pkg;

  localparam int         BYTE_W    = 8;
  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_EMIT,
    ST_FINISH
  } state_t;

  // MSB-first serial CRC: feedback is the outgoing MSB xor the new bit.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    crc8_step = {crc[6:0], 1'b0} ^ (((crc[7] ^ din) == 1'b1) ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/scan_chain_loader_if.sv
// Host byte streams of the scan chain loader: bytes in to shift, captured bytes out.
// master = host side, slave = controller side.
interface scan_chain_loader_if;
  import scan_chain_loader_pkg::*;

  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [BYTE_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/scan_chain_loader_crc8.sv
// Serial CRC-8 (poly 0x07, init 0) over captured scan_out bits; one bit per enabled cycle.
// Instantiated by scan_chain_loader only when SCAN_CRC_EN is defined.
module scan_chain_loader_crc8
  import scan_chain_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      crc <= 8'h00;
    end else if (en) begin
      crc <= crc8_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/scan_chain_loader.sv
// Byte-stream to scan-chain controller: shifts CHAIN_LEN bits in MSB first, returns captured bytes.
// Optional crc_out (CRC-8 of captured bits) when SCAN_CRC_EN is defined.
module scan_chain_loader
  import scan_chain_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 64
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  scan_chain_loader_if.slave bus,
  output logic               scan_enable,
  output logic               scan_in,
  input  logic               scan_out,
  output logic               cpu_halt,
  output logic               done
`ifdef SCAN_CRC_EN
  ,
  output logic [7:0]         crc_out
`endif
);

  localparam int REM_W = $clog2(CHAIN_LEN + 1);

  state_t            state, state_n;
  logic [BYTE_W-1:0] sreg;
  logic [BYTE_W-1:0] cap;
  logic [3:0]        bits;
  logic [REM_W-1:0]  rem;
  logic [3:0]        load_bits;

  logic              in_ready_c;
  logic              out_valid_c;
  logic [BYTE_W-1:0] out_data_c;

  // The last byte of a chain that is not a multiple of 8 shifts only the remaining bits.
  assign load_bits = (int'(rem) >= BYTE_W) ? 4'(BYTE_W) : 4'(rem);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    out_data_c  = '0;
    scan_enable = 1'b0;
    scan_in     = 1'b0;
    done        = 1'b0;
    cpu_halt    = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (start) state_n = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_n = ST_SHIFT;
      end
      ST_SHIFT: begin
        scan_enable = 1'b1;
        scan_in     = sreg[BYTE_W-1];
        if (bits == 4'd1) state_n = ST_EMIT;
      end
      ST_EMIT: begin
        out_valid_c = 1'b1;
        out_data_c  = cap;
        if (bus.out_ready) state_n = (rem == '0) ? ST_FINISH : ST_LOAD;
      end
      ST_FINISH: begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
      cap  <= '0;
      bits <= 4'd0;
      rem  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) rem <= REM_W'(CHAIN_LEN);
        end
        ST_LOAD: begin
          if (bus.in_valid) begin
            sreg <= bus.in_data;
            cap  <= '0;
            bits <= load_bits;
          end
        end
        ST_SHIFT: begin
          sreg <= {sreg[BYTE_W-2:0], 1'b0};
          cap  <= {cap[BYTE_W-2:0], scan_out};
          bits <= bits - 4'd1;
          rem  <= rem - REM_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_data_c;

`ifdef SCAN_CRC_EN
  scan_chain_loader_crc8 u_crc (
    .clk    (clk),
    .rst    (rst),
    .clear  ((state == ST_IDLE) && start),
    .en     (state == ST_SHIFT),
    .bit_in (scan_out),
    .crc    (crc_out)
  );
`endif

endmodule
